alu_arbiter: RTL

Shares one combinational `alu` instance between `N_REQ` independent requesters in the single-cycle datapath, e.g. the execute stage and an address-generation or CSR helper. Each requester issues an operation over a valid/ready handshake. A round-robin arbiter selects one requester per cycle and drives the shared ALU. The result and zero flag are registered into a one-entry response slot, which is returned to the winning requester over a per-requester valid/ready handshake.

---
 rtl/types_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// Shared datapath types: machine word, ALU operation encoding and the
// requester count used when the ALU arbiter is instantiated.
package types_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } aluop_e;

  // Number of units sharing the single ALU (execute stage + helper)
  localparam int N_ALU_REQ = 2;

  // Occupancy of the one-entry response slot in alu_arbiter
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches ptr, ptr+1, ... wrapping
// modulo N and grants the first asserted request. The pointer register
// itself lives in the caller so it can decide when rotation happens.
module rr_arbiter #(
  parameter  int N    = 2,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic            en,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  // Walk the requests starting at ptr and take the first valid one
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    if (en) begin
      for (int off = 0; off < N; off++) begin
        idx = ID_W'((int'(ptr) + off) % N);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          grant_id   = idx;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between N_REQ requesters. A round-robin
// grant picks one operation per cycle, the ALU output is captured into a
// one-entry response slot, and the slot is returned to its owner over a
// per-requester valid/ready handshake. A new grant may reuse the slot in
// the same cycle it is being drained, so a steady stream runs without
// bubbles.
module alu_arbiter
  import types_pkg::*;
#(
  parameter  int N_REQ = N_ALU_REQ,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  word_t            req_a [N_REQ],
  input  word_t            req_b [N_REQ],
  input  aluop_e           req_op [N_REQ],
  output logic [N_REQ-1:0] rsp_valid,
  input  logic [N_REQ-1:0] rsp_ready,
  output word_t            rsp_result,
  output logic             rsp_zero,
  output word_t            alu_a,
  output word_t            alu_b,
  output aluop_e           alu_control,
  input  word_t            alu_result,
  input  logic             alu_zero
);

  slot_e           slot_q, slot_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  word_t           res_q, res_d;
  logic            zero_q, zero_d;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grantId;
  logic             anyGrant;
  logic             drain;
  logic             acceptEn;

  // The slot can take a new op when empty or when its owner drains it now;
  // reset blocks acceptance so nothing is handshaken while rst is high
  always_comb begin
    drain    = (slot_q == SLOT_FULL) && rsp_ready[id_q];
    acceptEn = !rst && ((slot_q == SLOT_EMPTY) || drain);
    anyGrant = |grant;
    req_ready = grant;
  end

  rr_arbiter #(
    .N(N_REQ)
  ) uArb (
    .req      (req_valid),
    .en       (acceptEn),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_id (grantId)
  );

  // Route the winner's operands to the shared ALU; park it on ADD 0,0 when idle
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    if (anyGrant) begin
      alu_a       = req_a[grantId];
      alu_b       = req_b[grantId];
      alu_control = req_op[grantId];
    end
  end

  // Next slot contents and pointer: a grant refills the slot (even while
  // draining), a drain alone empties it, and the pointer moves only on grants
  always_comb begin
    slot_d = slot_q;
    id_d   = id_q;
    res_d  = res_q;
    zero_d = zero_q;
    ptr_d  = ptr_q;
    if (anyGrant) begin
      slot_d = SLOT_FULL;
      id_d   = grantId;
      res_d  = alu_result;
      zero_d = alu_zero;
      if (grantId == ID_W'(N_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grantId + ID_W'(1);
      end
    end else if (drain) begin
      slot_d = SLOT_EMPTY;
      res_d  = '0;
      zero_d = 1'b0;
    end
  end

  // Slot and pointer registers; reset discards any pending response
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= SLOT_EMPTY;
      id_q   <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      ptr_q  <= '0;
    end else begin
      slot_q <= slot_d;
      id_q   <= id_d;
      res_q  <= res_d;
      zero_q <= zero_d;
      ptr_q  <= ptr_d;
    end
  end

  // Present the slot to its owner only; the shared result bus reads 0 when empty
  always_comb begin
    rsp_valid  = '0;
    rsp_result = '0;
    rsp_zero   = 1'b0;
    if (slot_q == SLOT_FULL) begin
      rsp_valid[id_q] = 1'b1;
      rsp_result      = res_q;
      rsp_zero        = zero_q;
    end
  end

endmodule
